alu_issuer: RTL and testbench
=============================

Name: alu_issuer

Overview:
- Initiator side of the ALU command interface: accepts one operation at a time from the control front end over a valid/ready request channel.
- Drives the ALU's enable/cmd/op1/op2 inputs, waits the fixed ALU latency and captures the ALU result.
- Returns the captured result on a valid/ready response channel.
- Screens illegal requests (unknown command, divide by zero) without touching the ALU.

Parameters:
- DATA_W, 16, operand/result width; must match the ALU's data width.
- ALU_LAT, 2, cycles the ALU needs with enable held before its result is valid; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  issuer can accept a request
- req_cmd  in  4  0=add 1=sub 2=mul 3=div 4=inv; 5..15 illegal
- req_op1  in  DATA_W  first operand
- req_op2  in  DATA_W  second operand; ignored for inv
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_result  out  DATA_W  ALU result; 0 on error
- rsp_error  out  1  request was illegal; ALU not used
- alu_enable  out  1  ALU enable
- alu_cmd  out  4  ALU command
- alu_op1  out  DATA_W  ALU operand 1
- alu_op2  out  DATA_W  ALU operand 2
- alu_result  in  DATA_W  ALU result
- busy  out  1  state != IDLE

Behaviour:
- Clocking and reset:
  - Single clock domain; all outputs are registered or decoded from registered state.
  - reset_n low, asynchronous: state=IDLE, wait counter=0, alu_enable=0, alu_cmd=0, alu_op1=0, alu_op2=0, rsp_valid=0, rsp_result=0, rsp_error=0, busy=0.
  - req_ready=0 while reset_n is low. It is 1 only in IDLE with reset_n high.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready, capture cmd/op1/op2.
  - Illegal request (cmd>4, or cmd==3 with op2==0) -> RESP with rsp_error=1, rsp_result=0.
  - Legal request -> ISSUE.
- ISSUE (1 cycle):
  - alu_enable=1; alu_cmd/op1/op2 = captured values.
  - Load wait counter with ALU_LAT-1, then -> WAIT.
- WAIT:
  - alu_enable and the ALU inputs are held stable.
  - Counter decrements each cycle. When the counter is 0, capture alu_result into rsp_result, set rsp_error=0 and -> RESP.
  - WAIT lasts exactly ALU_LAT cycles.
- RESP:
  - alu_enable=0; alu_cmd/op1/op2 return to 0.
  - rsp_valid=1; rsp_result and rsp_error are held stable until rsp_valid & rsp_ready.
  - On that handshake -> IDLE. rsp_valid deasserts the next cycle.
- Latency, measured from the acceptance edge:
  - Legal op: rsp_valid high ALU_LAT+1 cycles later; alu_enable high for ALU_LAT+1 cycles.
  - Illegal op: rsp_valid high 1 cycle later; alu_enable never asserts.
- Throughput and backpressure:
  - One op outstanding. New acceptance is only possible in IDLE, so the minimum interval is ALU_LAT+3 cycles (legal) or 2 cycles (illegal).
  - rsp_ready held low stalls indefinitely in RESP; req_ready stays 0 throughout.
- Width rules: the issuer does no arithmetic on data. Results are passed through unmodified; truncation and overflow are the ALU's responsibility.
- Boundary cases:
  - req_valid while busy is ignored and not captured. The requester must hold it.
  - cmd=4 with op2=0 is legal.
  - ALU_LAT=1: the counter loads 0, giving a single WAIT cycle.
  - Reset mid-operation: ALU outputs drop at once, the in-flight op is discarded and no response is produced.

Optional Feature:
- Macro: ALU_ISSUER_TAG_EN.
- Defined:
  - Adds parameter TAG_W (default 4), port req_tag (in, TAG_W) and port rsp_tag (out, TAG_W).
  - req_tag is captured on acceptance and presented on rsp_tag for the entire RESP state. This applies to both legal and error responses.
  - rsp_tag resets to 0.
- Undefined: the parameter and ports are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, then add: ALU_LAT=2, cmd=0, op1=5, op2=7, rsp_ready=1 -> alu_enable high 3 cycles with cmd=0/5/7; rsp_valid 3 cycles after acceptance; rsp_result=12, rsp_error=0.
- Divide by zero: cmd=3, op1=9, op2=0 -> alu_enable stays 0; rsp_valid the next cycle; rsp_error=1, rsp_result=0.
- Illegal command: cmd=7, op1=1, op2=1 -> same as divide by zero (error, no ALU activity). Then cmd=2, 6*4 -> rsp_result=24.
- Backpressure: sub 10-3 with rsp_ready low 5 cycles -> rsp_valid=1, rsp_result=7 stable; req_ready=0; a second request held on req_valid is accepted only the cycle after the response handshake.
- Reset mid-WAIT: start mul 3*3, pull reset_n low during WAIT -> alu_enable 0 immediately; no rsp_valid. After release, inv op1=0x00FF -> rsp_result=0xFF00.
- With ALU_ISSUER_TAG_EN: add 1+1 tagged 0xA, then a div-by-zero request tagged 0x3 -> rsp_tag 0xA with result 2, then 0x3 with rsp_error=1.

Source files
------------

// File: rtl/alu_issuer_if.sv
// Request, response and ALU-side signals of the ALU issuer.
// ALU_ISSUER_TAG_EN adds the request/response tag pair.
interface alu_issuer_if #(
    parameter int DATA_W = 16
`ifdef ALU_ISSUER_TAG_EN
    , parameter int TAG_W = 4
`endif
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_cmd;
    logic [DATA_W-1:0] req_op1;
    logic [DATA_W-1:0] req_op2;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_error;
    logic              alu_enable;
    logic [3:0]        alu_cmd;
    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    logic [DATA_W-1:0] alu_result;
`ifdef ALU_ISSUER_TAG_EN
    logic [TAG_W-1:0]  req_tag;
    logic [TAG_W-1:0]  rsp_tag;
`endif

    // Issuer side
    modport slave (
        input  req_valid, req_cmd, req_op1, req_op2, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_result, rsp_error,
        output alu_enable, alu_cmd, alu_op1, alu_op2
`ifdef ALU_ISSUER_TAG_EN
        , input req_tag, output rsp_tag
`endif
    );

    // Front end / ALU side
    modport master (
        output req_valid, req_cmd, req_op1, req_op2, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_result, rsp_error,
        input  alu_enable, alu_cmd, alu_op1, alu_op2
`ifdef ALU_ISSUER_TAG_EN
        , output req_tag, input rsp_tag
`endif
    );
endinterface

// File: rtl/alu_issuer.sv
// Issues one ALU operation at a time, waits the fixed ALU latency, returns the result.
// Optional request/response tagging under ALU_ISSUER_TAG_EN.
module alu_issuer #(
    parameter int DATA_W  = 16,
    parameter int ALU_LAT = 2
`ifdef ALU_ISSUER_TAG_EN
    , parameter int TAG_W = 4
`endif
) (
    input  logic             clock,
    input  logic             reset_n,
    alu_issuer_if.slave      bus,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              err_q, err_d;
    logic              req_illegal;
    logic              alu_en;
`ifdef ALU_ISSUER_TAG_EN
    logic [TAG_W-1:0]  tag_q, tag_d;
`endif

    assign req_illegal = (bus.req_cmd > 4'd4) || (bus.req_cmd == 4'd3 && bus.req_op2 == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
`ifdef ALU_ISSUER_TAG_EN
            tag_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            res_q   <= res_d;
            err_q   <= err_d;
`ifdef ALU_ISSUER_TAG_EN
            tag_q   <= tag_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        res_d   = res_q;
        err_d   = err_q;
`ifdef ALU_ISSUER_TAG_EN
        tag_d   = tag_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    cmd_d = bus.req_cmd;
                    op1_d = bus.req_op1;
                    op2_d = bus.req_op2;
`ifdef ALU_ISSUER_TAG_EN
                    tag_d = bus.req_tag;
`endif
                    // Illegal requests bypass the ALU entirely
                    if (req_illegal) begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    res_d   = bus.alu_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ALU inputs are forced to zero outside ISSUE/WAIT so they drop at once on reset
    assign alu_en         = (state_q == ISSUE) || (state_q == WAIT);
    assign bus.alu_enable = alu_en;
    assign bus.alu_cmd    = alu_en ? cmd_q : '0;
    assign bus.alu_op1    = alu_en ? op1_q : '0;
    assign bus.alu_op2    = alu_en ? op2_q : '0;

    assign bus.req_ready  = (state_q == IDLE) && reset_n;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_result = res_q;
    assign bus.rsp_error  = err_q;
    assign busy           = (state_q != IDLE);
`ifdef ALU_ISSUER_TAG_EN
    assign bus.rsp_tag    = tag_q;
`endif
endmodule

// File: tb/tb_alu_issuer.sv
// Bench for alu_issuer: transaction-level model plus a latency-checking ALU stand-in.
module tb_alu_issuer;
    localparam int DW  = 16;
    localparam int LAT = 2;
`ifdef ALU_ISSUER_TAG_EN
    localparam int TW  = 4;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic busy;
    int   total = 0;
    int   bad   = 0;

`ifdef ALU_ISSUER_TAG_EN
    alu_issuer_if #(.DATA_W(DW), .TAG_W(TW)) bus ();
    alu_issuer #(.DATA_W(DW), .ALU_LAT(LAT), .TAG_W(TW)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus), .busy(busy));
`else
    alu_issuer_if #(.DATA_W(DW)) bus ();
    alu_issuer #(.DATA_W(DW), .ALU_LAT(LAT)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus), .busy(busy));
`endif

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] alu_fn(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (c)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a * b;
            4'd3: r = (b == '0) ? '0 : a / b;
            4'd4: r = ~a;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ALU stand-in: the result is only correct once enable has been held ALU_LAT cycles
    int en_cnt;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) en_cnt <= 0;
        else          en_cnt <= bus.alu_enable ? en_cnt + 1 : 0;
    end
    assign bus.alu_result = (bus.alu_enable && en_cnt >= LAT)
                          ? alu_fn(bus.alu_cmd, bus.alu_op1, bus.alu_op2)
                          : (16'hBAD0 ^ DW'(en_cnt));

    // Transaction model: one op in flight, m_k = clock edges since its acceptance
    logic          m_busy = 1'b0, m_legal = 1'b0, m_err = 1'b0;
    logic [3:0]    m_cmd = '0;
    logic [DW-1:0] m_op1 = '0, m_op2 = '0, m_res = '0;
    logic [3:0]    m_tag = '0;
    int            m_k = 0, m_acc = 0;

    function automatic logic model_rv();
        return m_busy && (!m_legal || m_k >= LAT + 1);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0;
            m_k    <= 0;
        end else if (!m_busy) begin
            if (bus.req_valid) begin
                logic lg;
                lg = !(bus.req_cmd > 4'd4 || (bus.req_cmd == 4'd3 && bus.req_op2 == '0));
                m_busy  <= 1'b1;
                m_k     <= 0;
                m_acc   <= m_acc + 1;
                m_legal <= lg;
                m_cmd   <= bus.req_cmd;
                m_op1   <= bus.req_op1;
                m_op2   <= bus.req_op2;
                m_res   <= lg ? alu_fn(bus.req_cmd, bus.req_op1, bus.req_op2) : '0;
                m_err   <= !lg;
`ifdef ALU_ISSUER_TAG_EN
                m_tag   <= 4'(bus.req_tag);
`endif
            end
        end else if (model_rv() && bus.rsp_ready) begin
            m_busy <= 1'b0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    always @(negedge clock) begin
        logic rv, en;
        rv = model_rv();
        en = m_busy && m_legal && (m_k <= LAT);
        check("req_ready", bus.req_ready, reset_n && !m_busy);
        check("busy", busy, m_busy);
        check("rsp_valid", bus.rsp_valid, rv);
        check("alu_enable", bus.alu_enable, en);
        check("alu_cmd", bus.alu_cmd, en ? m_cmd : 4'd0);
        check("alu_op1", bus.alu_op1, en ? m_op1 : '0);
        check("alu_op2", bus.alu_op2, en ? m_op2 : '0);
        if (rv) begin
            check("rsp_result", bus.rsp_result, m_res);
            check("rsp_error", bus.rsp_error, m_err);
`ifdef ALU_ISSUER_TAG_EN
            check("rsp_tag", bus.rsp_tag, m_tag);
`endif
        end
    end

    task automatic drive(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] tg);
        bus.req_valid = 1'b1;
        bus.req_cmd   = c;
        bus.req_op1   = a;
        bus.req_op2   = b;
`ifdef ALU_ISSUER_TAG_EN
        bus.req_tag   = TW'(tg);
`endif
    endtask

    task automatic wait_accept(input string nm);
        int start, t;
        start = m_acc;
        t = 0;
        while (m_acc == start && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) begin
            total++;
            bad++;
            $display("FAIL %s_accept: no acceptance within 50 cycles", nm);
        end
    endtask

    // Entered and left on a negedge; latency counts edges after the accepting edge
    task automatic run_op(input string nm, input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [3:0] tg, input int stall, input bit hold_next,
                          input logic [DW-1:0] exp_res, input logic exp_err, input int exp_lat, input int exp_en);
        int d, encnt;
        drive(c, a, b, tg);
        bus.rsp_ready = (stall == 0);
        wait_accept(nm);
        bus.req_valid = 1'b0;
        d = 0;
        encnt = 0;
        while (!bus.rsp_valid && d < 50) begin
            if (bus.alu_enable) encnt++;
            @(negedge clock);
            d++;
        end
        check({nm, "_latency"}, d, exp_lat);
        check({nm, "_en_cycles"}, encnt, exp_en);
        check({nm, "_result"}, bus.rsp_result, exp_res);
        check({nm, "_error"}, bus.rsp_error, exp_err);
`ifdef ALU_ISSUER_TAG_EN
        check({nm, "_tag"}, bus.rsp_tag, tg);
`endif
        if (hold_next) drive(4'd0, 16'd2, 16'd2, 4'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            check({nm, "_stall_valid"}, bus.rsp_valid, 1'b1);
            check({nm, "_stall_result"}, bus.rsp_result, exp_res);
            check({nm, "_stall_ready"}, bus.req_ready, 1'b0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        check({nm, "_rsp_drop"}, bus.rsp_valid, 1'b0);
        if (hold_next) begin
            check({nm, "_held_idle"}, busy, 1'b0);
            @(negedge clock);
            check({nm, "_held_accept"}, bus.alu_enable, 1'b1);
            bus.req_valid = 1'b0;
            d = 0;
            while (!bus.rsp_valid && d < 50) begin
                @(negedge clock);
                d++;
            end
            check({nm, "_held_result"}, bus.rsp_result, 16'd4);
            @(negedge clock);
        end
    endtask

    initial begin
        int n_ops, last;
        bus.req_valid = 1'b0;
        bus.req_cmd   = '0;
        bus.req_op1   = '0;
        bus.req_op2   = '0;
        bus.rsp_ready = 1'b1;
`ifdef ALU_ISSUER_TAG_EN
        bus.req_tag   = '0;
`endif
        #12;
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_alu_enable", bus.alu_enable, 1'b0);
        check("rst_alu_cmd", bus.alu_cmd, 4'd0);
        check("rst_alu_op1", bus.alu_op1, 16'd0);
        check("rst_alu_op2", bus.alu_op2, 16'd0);
        check("rst_rsp_result", bus.rsp_result, 16'd0);
        check("rst_rsp_error", bus.rsp_error, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        run_op("add",     4'd0, 16'd5,  16'd7, 4'd1, 0, 1'b0, 16'd12, 1'b0, 3, 3);
        run_op("div0",    4'd3, 16'd9,  16'd0, 4'd2, 0, 1'b0, 16'd0,  1'b1, 0, 0);
        run_op("illegal", 4'd7, 16'd1,  16'd1, 4'd3, 0, 1'b0, 16'd0,  1'b1, 0, 0);
        run_op("mul",     4'd2, 16'd6,  16'd4, 4'd4, 0, 1'b0, 16'd24, 1'b0, 3, 3);
        run_op("inv_z",   4'd4, 16'h1234, 16'd0, 4'd5, 0, 1'b0, 16'hEDCB, 1'b0, 3, 3);
        run_op("bp_sub",  4'd1, 16'd10, 16'd3, 4'd6, 5, 1'b1, 16'd7,  1'b0, 3, 3);

        // Reset during WAIT: ALU side must drop immediately and no response appears
        drive(4'd2, 16'd3, 16'd3, 4'd0);
        wait_accept("rst_mid");
        bus.req_valid = 1'b0;
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_alu_enable", bus.alu_enable, 1'b0);
        check("midrst_alu_cmd", bus.alu_cmd, 4'd0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("midrst_no_rsp", bus.rsp_valid, 1'b0);
        end
        run_op("inv",      4'd4, 16'h00FF, 16'd9, 4'd0, 0, 1'b0, 16'hFF00, 1'b0, 3, 3);
        run_op("tag_add",  4'd0, 16'd1, 16'd1, 4'hA, 0, 1'b0, 16'd2, 1'b0, 3, 3);
        run_op("tag_div0", 4'd3, 16'd5, 16'd0, 4'h3, 0, 1'b0, 16'd0, 1'b1, 0, 0);

        // Random traffic with random backpressure; next request presented while busy
        n_ops = 0;
        last  = m_acc;
        repeat (1500) begin
            @(negedge clock);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            if (m_acc != last) begin
                last = m_acc;
                bus.req_valid = 1'b0;
                n_ops++;
            end
            if (!bus.req_valid && n_ops < 80 && $urandom_range(0, 2) != 0)
                drive(($urandom_range(0, 3) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4)),
                      DW'($urandom),
                      ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom),
                      4'($urandom));
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (LAT + 4) @(negedge clock);
        check("drain_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
